// File: rtl/arch_defs_pkg.sv
// Shared SAP architecture definitions: PC width, breakpoint limit and the
// execution-controller state / halt-cause encodings.
package arch_defs_pkg;

   localparam int ADDR_WIDTH = 4;
   localparam int MAX_BP     = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } exec_state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE    = 3'd0,
      CAUSE_HLT     = 3'd1,
      CAUSE_BREAK   = 3'd2,
      CAUSE_USER    = 3'd3,
      CAUSE_TIMEOUT = 3'd4,
      CAUSE_STEP    = 3'd5
   } halt_cause_t;

   function automatic logic is_active(input exec_state_t s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/exec_bp_match.sv
// Combinational breakpoint comparator: flags when the PC equals any enabled
// breakpoint address (bp0 in the LSBs of the packed address bus).
module exec_bp_match
   import arch_defs_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_BP     = 2
)(
   input  logic [ADDR_WIDTH-1:0]        pc_i,
   input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr_i,
   input  logic [NUM_BP-1:0]            bp_en_i,
   output logic                         hit_o
);

   // OR-reduce the per-breakpoint equality compares
   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (bp_en_i[i] && (bp_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == pc_i)) begin
            hit_o = 1'b1;
         end else begin
            hit_o = hit_o;
         end
      end
   end

endmodule

// File: rtl/exec_ctrl.sv
// Run/step/halt execution controller for the SAP core. Optional macro
// EXEC_CTRL_PERF_EN builds the cycle/instruction counters and the cycle timeout.
module exec_ctrl
   import arch_defs_pkg::*;
#(
   parameter int ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH,
   parameter int NUM_BP     = 2,
   parameter int CNT_WIDTH  = 16,
   parameter int MAX_CYCLES = 0
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run_i,
   input  logic                         step_i,
   input  logic                         halt_req_i,
   input  logic                         hlt_decoded_i,
   input  logic                         instr_done_i,
   input  logic [ADDR_WIDTH-1:0]        pc_i,
   input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr_i,
   input  logic [NUM_BP-1:0]            bp_en_i,
   output logic                         core_en_o,
   output logic                         halted_o,
   output logic [1:0]                   state_o,
   output logic [2:0]                   halt_cause_o,
   output logic [CNT_WIDTH-1:0]         cycle_count_o,
   output logic [CNT_WIDTH-1:0]         instr_count_o
);

   localparam bit TIMEOUT_EN = (MAX_CYCLES != 32'sd0);

   exec_state_t state_q, state_d;
   halt_cause_t cause_q, cause_d;
   logic        bp_skip_q, bp_skip_d;
   logic        core_en_q, halted_q;
   logic        bp_hit_s, timeout_s;

   exec_bp_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_BP     (NUM_BP)
   ) u_bp_match (
      .pc_i      (pc_i),
      .bp_addr_i (bp_addr_i),
      .bp_en_i   (bp_en_i),
      .hit_o     (bp_hit_s)
   );

`ifdef EXEC_CTRL_PERF_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_AT = CNT_WIDTH'(MAX_CYCLES - 1);

   logic [CNT_WIDTH-1:0] cycle_q, instr_q;

   // Saturating counters of enabled cycles and retired instructions
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= {CNT_WIDTH{1'b0}};
         instr_q <= {CNT_WIDTH{1'b0}};
      end else begin
         if (core_en_q && (cycle_q != CNT_MAX)) cycle_q <= cycle_q + CNT_ONE;
         if (core_en_q && instr_done_i && (instr_q != CNT_MAX)) instr_q <= instr_q + CNT_ONE;
      end
   end

   assign timeout_s     = TIMEOUT_EN && core_en_q && (cycle_q == TIMEOUT_AT);
   assign cycle_count_o = cycle_q;
   assign instr_count_o = instr_q;
`else
   // Without counters there is nothing to time out against
   assign timeout_s     = TIMEOUT_EN && 1'b0;
   assign cycle_count_o = {CNT_WIDTH{1'b0}};
   assign instr_count_o = {CNT_WIDTH{1'b0}};
`endif

   // Next state, halt cause and breakpoint-skip flag
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      bp_skip_d = bp_skip_q;
      case (state_q)
         ST_IDLE: begin
            if (run_i)       state_d = ST_RUN;
            else if (step_i) state_d = ST_STEP;
            else             state_d = ST_IDLE;
         end
         ST_RUN, ST_STEP: begin
            if (instr_done_i) bp_skip_d = 1'b0;
            else              bp_skip_d = bp_skip_q;
            if (hlt_decoded_i) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_HLT;
            end else if (instr_done_i && !bp_skip_q && bp_hit_s) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_BREAK;
            end else if (halt_req_i) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_USER;
            end else if (timeout_s) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_TIMEOUT;
            end else if ((state_q == ST_STEP) && instr_done_i) begin
               state_d = ST_HALTED;
               cause_d = CAUSE_STEP;
            end else begin
               state_d = state_q;
            end
         end
         ST_HALTED: begin
            // HLT is terminal until reset; other causes can resume
            if (cause_q == CAUSE_HLT) begin
               state_d = ST_HALTED;
            end else if (run_i) begin
               state_d   = ST_RUN;
               bp_skip_d = (cause_q == CAUSE_BREAK);
            end else if (step_i) begin
               state_d   = ST_STEP;
               bp_skip_d = (cause_q == CAUSE_BREAK);
            end else begin
               state_d = ST_HALTED;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cause_d   = CAUSE_NONE;
            bp_skip_d = 1'b0;
         end
      endcase
   end

   // State register with registered enable/halted decodes
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cause_q   <= CAUSE_NONE;
         bp_skip_q <= 1'b0;
         core_en_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         bp_skip_q <= bp_skip_d;
         core_en_q <= is_active(state_d);
         halted_q  <= (state_d == ST_HALTED);
      end
   end

   assign core_en_o    = core_en_q;
   assign halted_o     = halted_q;
   assign state_o      = state_q;
   assign halt_cause_o = cause_q;

endmodule
